// File: rtl/alu_regfile_if.sv
// Operand-read, writeback and flag signals between the ALU datapath and its register file.
interface alu_regfile_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] alu_rs1;
    logic [DATA_W-1:0] alu_rs2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] aluOut;
    logic              overflow;
    logic              clr_sticky;
    logic              cond_flag;
    logic              ovf_flag;
    logic              ovf_sticky;

    modport master (
        output rs1_addr, rs2_addr, wr_en, wr_addr, opcode, aluOut, overflow, clr_sticky,
        input  alu_rs1, alu_rs2, cond_flag, ovf_flag, ovf_sticky
    );

    modport slave (
        input  rs1_addr, rs2_addr, wr_en, wr_addr, opcode, aluOut, overflow, clr_sticky,
        output alu_rs1, alu_rs2, cond_flag, ovf_flag, ovf_sticky
    );
endinterface

// File: rtl/alu_regfile.sv
// Operand register file with a one-entry writeback stage, read bypass from that stage,
// and the compare / overflow flags produced by the ALU.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input logic         clk,
    input logic         reset_n,
    alu_regfile_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              cond_q;
    logic              ovf_q;
    logic              sticky_q;

    logic is_arith;
    logic is_cmp;
    logic is_logic;

    always_comb begin
        is_arith = 1'b0;
        is_cmp   = 1'b0;
        is_logic = 1'b0;
        case (bus.opcode)
            4'b0000, 4'b0001, 4'b0010:                   is_arith = 1'b1;
            4'b0100, 4'b0101, 4'b0110:                   is_cmp   = 1'b1;
            4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1010: is_logic = 1'b1;
            default: ;
        endcase
    end

    // Writes to register 0 never enter the WB stage, so regs[0] stays at its reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            cond_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (wb_valid) begin
                regs[wb_addr] <= wb_data;
            end
            wb_valid <= bus.wr_en && (is_arith || is_logic) && (bus.wr_addr != '0);
            wb_addr  <= bus.wr_addr;
            wb_data  <= bus.aluOut;
            if (bus.wr_en && is_cmp) begin
                cond_q <= bus.aluOut[0];
            end
            if (bus.wr_en && is_arith) begin
                ovf_q <= bus.overflow;
            end
            // A new overflow beats a simultaneous clear.
            if (bus.wr_en && is_arith && bus.overflow) begin
                sticky_q <= 1'b1;
            end else if (bus.clr_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.alu_rs1 = (bus.rs1_addr == '0) ? '0 :
                         (wb_valid && (wb_addr == bus.rs1_addr)) ? wb_data : regs[bus.rs1_addr];
    assign bus.alu_rs2 = (bus.rs2_addr == '0) ? '0 :
                         (wb_valid && (wb_addr == bus.rs2_addr)) ? wb_data : regs[bus.rs2_addr];

    assign bus.cond_flag  = cond_q;
    assign bus.ovf_flag   = ovf_q;
    assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed vector table, hand-written reset and
// back-to-back sequences, then random traffic against an architectural register model.
module tb_alu_regfile;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_regfile_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    alu_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] opcode;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] data;
        logic       ovf;
        logic       clr;
        logic [2:0] rd_addr;
        logic [7:0] exp_rd;
        logic       exp_cond;
        logic       exp_ovf;
        logic       exp_sticky;
    } vec_t;

    // Architectural view: a legal write is visible to readers from the cycle after it is sampled.
    logic [7:0] arch [8];
    logic       m_cond;
    logic       m_ovf;
    logic       m_sticky;

    function automatic logic [7:0] model_read(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : arch[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) arch[i] = 8'h00;
        m_cond   = 1'b0;
        m_ovf    = 1'b0;
        m_sticky = 1'b0;
    endtask

    task automatic model_update(input logic [3:0] op, input logic we, input logic [2:0] addr,
                                input logic [7:0] data, input logic ovf, input logic clr);
        bit arith, cmp, logic_op;
        arith    = (op <= 4'd2);
        cmp      = (op >= 4'd4 && op <= 4'd6);
        logic_op = (op == 4'd3 || (op >= 4'd7 && op <= 4'd10));
        if (we && (arith || logic_op) && addr != 3'd0) arch[addr] = data;
        if (we && cmp) m_cond = data[0];
        if (we && arith) m_ovf = ovf;
        if (we && arith && ovf) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic we, input logic [2:0] addr,
                                 input logic [7:0] data, input logic ovf, input logic clr);
        bus.opcode     = op;
        bus.wr_en      = we;
        bus.wr_addr    = addr;
        bus.aluOut     = data;
        bus.overflow   = ovf;
        bus.clr_sticky = clr;
        @(posedge clk);
        model_update(op, we, addr, data, ovf, clr);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                               input logic [7:0] e1, input logic [7:0] e2,
                               input logic ec, input logic eo, input logic es);
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        #1;
        check({tag, ".rs1"},    bus.alu_rs1,           e1);
        check({tag, ".rs2"},    bus.alu_rs2,           e2);
        check({tag, ".cond"},   {7'd0, bus.cond_flag},  {7'd0, ec});
        check({tag, ".ovf"},    {7'd0, bus.ovf_flag},   {7'd0, eo});
        check({tag, ".sticky"}, {7'd0, bus.ovf_sticky}, {7'd0, es});
    endtask

    task automatic checkModel(input string tag, input logic [2:0] a1, input logic [2:0] a2);
        checkOutput(tag, a1, a2, model_read(a1), model_read(a2), m_cond, m_ovf, m_sticky);
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{4'h0, 1'b1, 3'd3, 8'h05, 1'b0, 1'b0, 3'd3, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'h0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 3'd3, 8'h05, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'hA, 1'b1, 3'd0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'h4, 1'b1, 3'd4, 8'h01, 1'b0, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'h0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'h5, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'h0, 1'b1, 3'd5, 8'h7F, 1'b1, 1'b0, 3'd5, 8'h7F, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{4'h2, 1'b1, 3'd6, 8'h10, 1'b0, 1'b0, 3'd6, 8'h10, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{4'h0, 1'b1, 3'd1, 8'h80, 1'b1, 1'b1, 3'd1, 8'h80, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'hC, 1'b1, 3'd2, 8'hAA, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'h7, 1'b1, 3'd7, 8'h3C, 1'b1, 1'b0, 3'd7, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'h1, 1'b1, 3'd7, 8'h01, 1'b0, 1'b0, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'h6, 1'b1, 3'd3, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h05, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0};

        bus.rs1_addr = 3'd0;
        bus.rs2_addr = 3'd0;
        bus.opcode = 4'h0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 3'd0;
        bus.aluOut = 8'h00;
        bus.overflow = 1'b0;
        bus.clr_sticky = 1'b0;
        model_reset();

        #2;
        checkOutput("reset_init", 3'd3, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].opcode, vecs[i].wr_en, vecs[i].wr_addr, vecs[i].data,
                          vecs[i].ovf, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].rd_addr,
                        vecs[i].exp_rd, vecs[i].exp_rd,
                        vecs[i].exp_cond, vecs[i].exp_ovf, vecs[i].exp_sticky);
        end

        $display("[TB] back-to-back writes to r2");
        applyStimulus(4'h0, 1'b1, 3'd2, 8'h11, 1'b0, 1'b0);
        checkOutput("b2b_first", 3'd2, 3'd3, 8'h11, 8'h05, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b1, 3'd2, 8'h22, 1'b0, 1'b0);
        checkOutput("b2b_second", 3'd2, 3'd2, 8'h22, 8'h22, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("b2b_commit", 3'd2, 3'd0, 8'h22, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("b2b_settled", 3'd2, 3'd2, 8'h22, 8'h22, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset between writeback capture and commit");
        applyStimulus(4'h4, 1'b1, 3'd0, 8'h01, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b1, 3'd6, 8'h5A, 1'b1, 1'b0);
        checkOutput("pre_reset", 3'd6, 3'd2, 8'h5A, 8'h22, 1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        bus.wr_en = 1'b0;
        model_reset();
        checkOutput("in_reset", 3'd6, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        applyStimulus(4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
        checkOutput("post_reset", 3'd6, 3'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] random traffic against model");
        for (int i = 0; i < 400; i++) begin
            logic [2:0] waddr;
            logic [2:0] a1;
            waddr = 3'($urandom_range(0, 7));
            applyStimulus(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), waddr,
                          8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            a1 = ($urandom_range(0, 1) == 0) ? waddr : 3'($urandom_range(0, 7));
            checkModel($sformatf("rand%0d", i), a1, 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
